// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding a UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_valid_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_ready_o,
    output logic              start_o,
    output logic [7:0]        tx_in_o,
    input  logic              tx_done_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    state_e            state_q;
    logic [7:0]        tx_in_q;
    logic [GAP_W-1:0]  gap_q;

    logic full, empty, push, pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    // Refusal at full uses registered state only, so a same-cycle pop cannot open a slot.
    assign push  = wr_valid_i && !full;
    assign pop   = (state_q == S_WAIT_DONE) && tx_done_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The in-flight byte keeps its slot until tx_done, so count covers it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tx_in_q <= 8'h00;
            gap_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        tx_in_q <= mem[rd_ptr_q];
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tx_done_i) begin
                        gap_q   <= GAP_LOAD;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start_o    = (state_q == S_LAUNCH);
    assign tx_in_o    = tx_in_q;
    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign wr_ready_o = !full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int GAP   = 12;
    localparam int FRAME = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic [7:0] tx_in;
    logic       tx_done;
    logic [4:0] count;
    logic       full;
    logic       empty;

    logic man_done;
    logic uart_done;
    logic uart_en;
    assign tx_done = man_done | uart_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .GAP_CYCLES(GAP)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_valid_i (wr_valid),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .start_o    (start),
        .tx_in_o    (tx_in),
        .tx_done_i  (tx_done),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int start_cnt = 0;
    int done_cyc  = 0;
    bit done_valid = 0;
    bit prev_start = 0;
    int uart_timer = 0;
    logic [7:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Output monitor, scoreboard and UART model share one sampling point
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 0;
            uart_timer = 0;
            uart_done  = 0;
            done_valid = 0;
        end else begin
            if (start) begin
                logic [7:0] exp_b;
                start_cnt++;
                check(!prev_start, "start_width", 1, 0);
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_start", int'(tx_in), -1);
                end else begin
                    exp_b = sb.pop_front();
                    check(tx_in == exp_b, "tx_in_order", int'(tx_in), int'(exp_b));
                end
                if (done_valid) begin
                    check(cyc - done_cyc >= GAP + 2, "gap_spacing", cyc - done_cyc, GAP + 2);
                    done_valid = 0;
                end
                if (uart_en) uart_timer = FRAME;
            end
            prev_start = start;
            uart_done = 0;
            if (uart_timer > 0) begin
                uart_timer--;
                if (uart_timer == 0) begin
                    uart_done  = 1;
                    done_cyc   = cyc;
                    done_valid = 1;
                end
            end
        end
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       done;
        logic [4:0] cnt;
        logic       f;
        logic       e;
        logic       r;
        logic       s;
    } vec_t;

    task automatic drive_push(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        if (wr_ready) sb.push_back(b);
    endtask

    task automatic wait_start(input int lim, input string nm);
        int n = 0;
        while (!start && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(start, nm, int'(start), 1);
    endtask

    task automatic push_when_ready(input logic [7:0] b);
        int n = 0;
        while (!wr_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(wr_ready, "push_ready_timeout", int'(wr_ready), 1);
        drive_push(b);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic drain(input int lim, input string nm);
        int n = 0;
        while (!(empty && sb.size() == 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(empty && sb.size() == 0, nm, sb.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int s0;
        int early;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        man_done = 1'b0; uart_en = 1'b0;
        vecs[0] = '{1'b1, 8'h01, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check({count, full, empty, wr_ready, start} == {5'd0, 1'b0, 1'b1, 1'b1, 1'b0},
              "reset_flags", {count, full, empty, wr_ready, start}, {5'd0, 4'b0110});
        check(tx_in == 8'h00, "reset_tx_in", int'(tx_in), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            wr_valid = vecs[i].v;
            wr_data  = vecs[i].d;
            man_done = vecs[i].done;
            if (vecs[i].v && wr_ready) sb.push_back(vecs[i].d);
            @(negedge clk);
            check({count, full, empty, wr_ready, start} ==
                  {vecs[i].cnt, vecs[i].f, vecs[i].e, vecs[i].r, vecs[i].s},
                  $sformatf("vec%0d", i), {count, full, empty, wr_ready, start},
                  {vecs[i].cnt, vecs[i].f, vecs[i].e, vecs[i].r, vecs[i].s});
        end
        wr_valid = 1'b0; man_done = 1'b0;

        drive_push(8'h03);
        @(negedge clk);
        drive_push(8'h04);
        @(negedge clk);
        wr_valid = 1'b0;
        check(count == 5'd3, "queued_before_reset", int'(count), 3);
        rst_n = 1'b0;
        #1;
        check({count, empty, start, tx_in} == {5'd0, 1'b1, 1'b0, 8'h00}, "reset_midstream",
              {count, empty, start, tx_in}, {5'd0, 1'b1, 1'b0, 8'h00});
        sb.delete();
        s0 = start_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check(start_cnt == s0, "no_start_after_reset", start_cnt - s0, 0);
        check(count == 5'd0, "count_after_reset", int'(count), 0);

        drive_push(8'hA5);
        @(negedge clk);
        wr_valid = 1'b0;
        check(!start && count == 5'd1, "single_before_launch", {count, start}, {5'd1, 1'b0});
        @(negedge clk);
        check(start && tx_in == 8'hA5, "single_launch", {start, tx_in}, {1'b1, 8'hA5});
        @(negedge clk);
        check(!start, "single_pulse_one_cycle", int'(start), 0);
        repeat (19) @(negedge clk);
        man_done = 1'b1;
        drive_push(8'hB6);
        @(negedge clk);
        man_done = 1'b0; wr_valid = 1'b0;
        check(count == 5'd1, "push_pop_same_edge", int'(count), 1);
        early = 0;
        for (int j = 2; j <= 14; j++) begin
            @(negedge clk);
            if (j == 5) man_done = 1'b1;
            if (j == 6) begin
                man_done = 1'b0;
                check(count == 5'd1, "spurious_done_gap", int'(count), 1);
            end
            if (j < 14 && start) early++;
        end
        check(early == 0, "gap_no_early_start", early, 0);
        check(start, "gap_exact_restart", int'(start), 1);
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check(count == 5'd0 && empty, "single_pop", {count, empty}, {5'd0, 1'b1});
        repeat (20) @(negedge clk);
        s0 = start_cnt;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check(count == 5'd0 && empty, "spurious_done_idle", {count, empty}, {5'd0, 1'b1});
        repeat (20) @(negedge clk);
        check(start_cnt == s0, "idle_no_start", start_cnt - s0, 0);

        uart_en = 1'b1;
        drive_push(8'h11); @(negedge clk);
        drive_push(8'h22); @(negedge clk);
        drive_push(8'h33); @(negedge clk);
        wr_valid = 1'b0;
        drain(500, "back_to_back_drain");
        uart_en = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            drive_push(8'h40 + 8'(i * 7));
            @(negedge clk);
        end
        check(count == 5'd16 && full && !wr_ready, "full_flags", {count, full, wr_ready},
              {5'd16, 1'b1, 1'b0});
        drive_push(8'hEE);
        @(negedge clk);
        wr_valid = 1'b0;
        check(count == 5'd16, "push_refused_at_full", int'(count), 16);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check(count == 5'd15 && wr_ready && !full, "pop_reopens", {count, wr_ready, full},
              {5'd15, 1'b1, 1'b0});
        wait_start(40, "launch_after_full_pop");
        @(negedge clk);
        man_done = 1'b1;
        drive_push(8'h99);
        @(negedge clk);
        man_done = 1'b0; wr_valid = 1'b0;
        check(count == 5'd15, "full_minus_one_push_pop", int'(count), 15);

        uart_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_when_ready(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(5000, "mixed_drain");
        check(count == 5'd0, "final_count", int'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
